// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit with architectural HI/LO registers.
//
// Purpose:
//   Multicycle MULT/MULTU/DIV/DIVU (and optionally MADD/MADDU) plus
//   single-cycle MTHI/MTLO. Operands are captured on the accepting edge. The
//   result is committed to HI/LO on the edge where busy falls, so new values
//   are visible in the first idle cycle.
//
// Optional feature:
//   MDU_MADD_EN -- when defined, op 4/5 perform {HI,LO} += A*B
//                  (signed/unsigned, 64-bit wrap, 5-cycle latency).
//                  When undefined, op 4/5 are ignored entirely.
//
// Ports:
//   clk        in   1   sole clock, rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   one-cycle launch request from the E stage
//   op         in   3   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MADD 5 MADDU 6 MTHI 7 MTLO
//   A          in  32   rs operand
//   B          in  32   rt operand
//   busy       out  1   multiply/divide in flight (counter != 0)
//   stall_req  out  1   combinational: start with a multicycle op, or busy
//   HI         out 32   architectural HI register
//   LO         out 32   architectural LO register
// -----------------------------------------------------------------------------
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] MUL_LAT = CW'(5);
  localparam logic [CW-1:0] DIV_LAT = CW'(10);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    op_q;

  logic          accept_c;
  logic          is_md_c;
  logic [CW-1:0] lat_c;

  logic [2*DW-1:0] prod_s_c;
  logic [2*DW-1:0] prod_u_c;
  logic [2*DW-1:0] prod_c;

  logic          neg_a_c;
  logic          neg_b_c;
  logic [DW-1:0] mag_a_c;
  logic [DW-1:0] mag_b_c;
  logic [DW-1:0] div_b_c;
  logic [DW-1:0] quot_mag_c;
  logic [DW-1:0] rem_mag_c;
  logic [DW-1:0] quot_c;
  logic [DW-1:0] rem_c;

  logic          commit_we_c;
  logic [DW-1:0] commit_hi_c;
  logic [DW-1:0] commit_lo_c;

  assign busy      = (cnt_q != '0);
  assign accept_c  = start & ~busy;
  assign stall_req = (start & is_md_c) | busy;

  // Decode incoming op: is it multicycle, and how long does it run.
  always_comb begin
    is_md_c = 1'b0;
    lat_c   = '0;
    case (op)
      OP_MULT, OP_MULTU: begin
        is_md_c = 1'b1;
        lat_c   = MUL_LAT;
      end
      OP_DIV, OP_DIVU: begin
        is_md_c = 1'b1;
        lat_c   = DIV_LAT;
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        is_md_c = 1'b1;
        lat_c   = MUL_LAT;
      end
`endif
      default: ;
    endcase
  end

  // 64-bit products; low 64 bits of the sign-extended product is the signed result.
  // op_q[0] selects the unsigned flavour for every mult/div/madd pair.
  assign prod_s_c = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_q[DW-1]}}, b_q};
  assign prod_u_c = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
  assign prod_c   = op_q[0] ? prod_u_c : prod_s_c;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. The divisor is forced non-zero so the datapath never
  // divides by zero; the B=0 result is discarded at commit anyway.
  always_comb begin
    neg_a_c    = ~op_q[0] & a_q[DW-1];
    neg_b_c    = ~op_q[0] & b_q[DW-1];
    mag_a_c    = neg_a_c ? (DW'(0) - a_q) : a_q;
    mag_b_c    = neg_b_c ? (DW'(0) - b_q) : b_q;
    div_b_c    = (mag_b_c == '0) ? DW'(1) : mag_b_c;
    quot_mag_c = mag_a_c / div_b_c;
    rem_mag_c  = mag_a_c % div_b_c;
    quot_c     = (neg_a_c ^ neg_b_c) ? (DW'(0) - quot_mag_c) : quot_mag_c;
    rem_c      = neg_a_c ? (DW'(0) - rem_mag_c) : rem_mag_c;
  end

  // Result to be written to HI/LO when the countdown reaches its last cycle.
  always_comb begin
    commit_we_c = 1'b0;
    commit_hi_c = HI;
    commit_lo_c = LO;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        commit_we_c = 1'b1;
        {commit_hi_c, commit_lo_c} = prod_c;
      end
      OP_DIV, OP_DIVU: begin
        if (b_q != '0) begin
          commit_we_c = 1'b1;
          commit_hi_c = rem_c;
          commit_lo_c = quot_c;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        commit_we_c = 1'b1;
        {commit_hi_c, commit_lo_c} = {HI, LO} + prod_c;
      end
`endif
      default: ;
    endcase
  end

  // Countdown and operand capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_MULT;
    end else if (accept_c && is_md_c) begin
      cnt_q <= lat_c;
      a_q   <= A;
      b_q   <= B;
      op_q  <= op;
    end else if (busy) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // HI/LO: commit on the falling edge of busy, or direct move when idle.
  // Accept only happens with cnt_q == 0, so the two paths never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (cnt_q == CW'(1)) begin
      if (commit_we_c) begin
        HI <= commit_hi_c;
        LO <= commit_lo_c;
      end
    end else if (accept_c) begin
      if (op == OP_MTHI) HI <= A;
      if (op == OP_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- directed self-checking bench for md_unit.
// Expected HI/LO pairs are pushed to a scoreboard queue when an op is issued
// and popped/compared once the unit goes idle. Honours MDU_MADD_EN.
// -----------------------------------------------------------------------------
module tb_md_unit;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADDU = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] sb_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  md_unit u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .stall_req (stall_req),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference for mult/div results.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] da;
    logic signed [31:0] db;
    logic [63:0] r;
    sa = $signed(a);
    sb = $signed(b);
    da = $signed(a);
    db = $signed(b);
    r  = {hi_m, lo_m};
    case (o)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIV:   if (b != 0) r = {32'(da % db), 32'(da / db)};
      OP_DIVU:  if (b != 0) r = {a % b, a / b};
      default:  ;
    endcase
    return r;
  endfunction

  // Drive a start for one cycle from the current negedge; checks stall_req.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    #1;
    check("stall_req", 32'(stall_req), 32'(exp_stall));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles (bounded), checking HI/LO hold their old values meanwhile.
  task automatic wait_done(input int lat, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      if (n == 2) begin
        check("hold_hi", HI, hi_m);
        check("hold_lo", LO, lo_m);
      end
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(lat));
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, HI, e[63:32]);
      check({tag, "_lo"}, LO, e[31:0]);
      hi_m = e[63:32];
      lo_m = e[31:0];
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp);
    sb_q.push_back(exp);
    issue(o, a, b, 1'b1);
    wait_done(lat, {tag, "_lat"});
    pop_check(tag);
  endtask

  task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
    sb_q.push_back({(o == OP_MTHI) ? a : hi_m, (o == OP_MTLO) ? a : lo_m});
    issue(o, a, 32'h0, 1'b0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    pop_check(tag);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
    hi_m  = '0;
    lo_m  = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    reset = 1'b0;

    run_md("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_md("divu", OP_DIVU, 32'd7, 32'd2, 10, {32'd1, 32'd3});

    run_mt("mthi", OP_MTHI, 32'h11);
    run_mt("mtlo", OP_MTLO, 32'h22);
    run_md("div0", OP_DIVU, 32'd5, 32'd0, 10, {32'h11, 32'h22});

    // Start during busy must be ignored; first result intact.
    sb_q.push_back({32'h0, 32'hC});
    issue(OP_MULTU, 32'd3, 32'd4, 1'b1);
    start = 1'b1;
    op    = OP_MULTU;
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    #1;
    check("stall_busy", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(4, "ign_lat");
    pop_check("ign");
    @(negedge clk);
    check("ign_idle", 32'(busy), 32'd0);

    run_mt("mtlo55", OP_MTLO, 32'h55);

    // Back-to-back: second op issued in the first idle cycle.
    run_md("b2b_mult", OP_MULT, 32'd2, 32'hFFFF_FFFD, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_md("b2b_divu", OP_DIVU, 32'd100, 32'd7, 10, {32'd2, 32'd14});

    // Reset in cycle 3 of a DIV: cleared, no late commit.
    issue(OP_DIV, 32'd100, 32'd3, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("late_hi", HI, 32'h0);
    check("late_lo", LO, 32'h0);
    hi_m = '0;
    lo_m = '0;

    run_mt("pre_lo", OP_MTLO, 32'hFFFF_FFFF);
    run_mt("pre_hi", OP_MTHI, 32'h0);
`ifdef MDU_MADD_EN
    run_md("maddu", OP_MADDU, 32'd1, 32'd1, 5, {32'h1, 32'h0});
`else
    issue(OP_MADDU, 32'd1, 32'd1, 1'b0);
    check("madd_off_busy", 32'(busy), 32'd0);
    check("madd_off_hi", HI, 32'h0);
    check("madd_off_lo", LO, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (ro[1] && rb == 32'h0) rb = 32'd1;
      if (ro == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      run_md("rnd", ro, ra, rb, ro[1] ? 10 : 5, model(ro, ra, rb));
    end

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    op    = OP_MULT;
    A     = 32'd5;
    B     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_hi", HI, 32'h0);
    @(negedge clk);
    check("rst_start_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
